// File: rtl/kamacore_pkg.sv
// kamacore_pkg: shared fetch-stage constants, fetch FSM states and the IF/ID slot type
package kamacore_pkg;
  localparam int CPU_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  typedef enum logic [1:0] {REQ, WAIT, HOLD} e_fetch_state;
  typedef struct packed {
    logic                 valid;
    logic [CPU_WIDTH-1:0] pc;
    logic [31:0]          instruction;
  } st_fetch_slot;
endpackage

// File: rtl/kamacore_fetch_hold_buffer.sv
// kamacore_fetch_hold_buffer: one-entry register parking a fetched instruction while decode stalls
module kamacore_fetch_hold_buffer (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_capture,
  input  logic        i_flush,
  input  logic [31:0] i_data,
  output logic        o_valid,
  output logic [31:0] o_data
);
  logic        r_valid;
  logic [31:0] r_data;
  always_ff @(posedge clk) begin
    if (!rst || i_flush) r_valid <= 1'b0;
    else if (i_capture) r_valid <= 1'b1;
    if (i_capture) r_data <= i_data;
  end
  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/kamacore_stage_if.sv
// kamacore_stage_if: instruction fetch stage with single-outstanding imem requests and IF/ID slot
// Define KAMACORE_IF_PERF_EN to add the perf_fetched / perf_bubbles counters.
module kamacore_stage_if
  import kamacore_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [CPU_WIDTH-1:0] redirect_pc,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [CPU_WIDTH-1:0] imem_req_addr,
  input  logic                 imem_rsp_valid,
  input  logic [31:0]          imem_rsp_data,
  output logic                 if_id_valid,
  output logic [CPU_WIDTH-1:0] if_id_pc,
  output logic [31:0]          if_id_instruction
`ifdef KAMACORE_IF_PERF_EN
  ,
  output logic [31:0]          perf_fetched,
  output logic [31:0]          perf_bubbles
`endif
);
  e_fetch_state         r_state, w_next_state;
  logic [CPU_WIDTH-1:0] r_pc, w_next_pc;
  logic                 r_drop, w_next_drop;
  st_fetch_slot         r_slot, w_next_slot;
  logic                 w_load, w_keep, w_capture, w_release;
  logic [31:0]          w_load_data;
  logic                 w_hold_valid;
  logic [31:0]          w_hold_data;

  kamacore_fetch_hold_buffer u_hold (
    .clk       (clk),
    .rst       (rst),
    .i_capture (w_capture),
    .i_flush   (redirect_valid || w_release),
    .i_data    (imem_rsp_data),
    .o_valid   (w_hold_valid),
    .o_data    (w_hold_data)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_drop  = r_drop;
    w_load       = 1'b0;
    w_load_data  = imem_rsp_data;
    w_capture    = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      REQ: begin
        // a response seen while not waiting can only be a leftover from before reset
        if (imem_rsp_valid) w_next_drop = 1'b0;
        if (imem_req_ready) begin
          w_next_state = WAIT;
          if (redirect_valid) w_next_drop = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          w_next_state = (r_drop || redirect_valid || !stall) ? REQ : HOLD;
          w_next_drop  = 1'b0;
          w_load       = !r_drop && !stall;
          w_capture    = !r_drop && stall;
        end else if (redirect_valid) w_next_drop = 1'b1;
      end
      HOLD: begin
        if (redirect_valid) w_next_state = REQ;
        else if (!stall && w_hold_valid) begin
          w_next_state = REQ;
          w_load       = 1'b1;
          w_load_data  = w_hold_data;
          w_release    = 1'b1;
        end
      end
      default: w_next_state = REQ;
    endcase
    if (w_load) w_next_pc = r_pc + CPU_WIDTH'(4);
    if (redirect_valid) begin
      w_next_pc = redirect_pc;
      w_load    = 1'b0;
      w_capture = 1'b0;
    end
    w_keep      = stall && !redirect_valid;
    w_next_slot = w_load ? st_fetch_slot'({1'b1, r_pc, w_load_data}) :
                  w_keep ? r_slot : st_fetch_slot'({1'b0, r_slot.pc, NOP_INSTR});
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= REQ;
      r_pc    <= RESET_PC;
      r_drop  <= (r_state == WAIT) || (r_drop && !imem_rsp_valid);
      r_slot  <= st_fetch_slot'({1'b0, {CPU_WIDTH{1'b0}}, NOP_INSTR});
    end else begin
      r_state <= w_next_state;
      r_pc    <= w_next_pc;
      r_drop  <= w_next_drop;
      r_slot  <= w_next_slot;
    end
  end

  assign imem_req_valid    = rst && (r_state == REQ);
  assign imem_req_addr     = r_pc;
  assign if_id_valid       = r_slot.valid;
  assign if_id_pc          = r_slot.pc;
  assign if_id_instruction = r_slot.instruction;

`ifdef KAMACORE_IF_PERF_EN
  logic        w_bubble;
  logic [31:0] r_perf_fetched, r_perf_bubbles;
  assign w_bubble = !w_load && !w_keep;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_fetched <= '0;
      r_perf_bubbles <= '0;
    end else begin
      if (w_load) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_bubble) r_perf_bubbles <= r_perf_bubbles + 32'd1;
    end
  end
  assign perf_fetched = r_perf_fetched;
  assign perf_bubbles = r_perf_bubbles;
`endif
endmodule

// File: tb/tb_kamacore_stage_if.sv
// tb_kamacore_stage_if: directed bench with imem responder model and expected-slot scoreboard
module tb_kamacore_stage_if;
  import kamacore_pkg::*;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk, rst, stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_id_valid;
  logic [31:0] if_id_pc, if_id_instruction;
`ifdef KAMACORE_IF_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  kamacore_stage_if #(.RESET_PC(RESET_PC)) dut (
    .clk               (clk),
    .rst               (rst),
    .stall             (stall),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .imem_req_valid    (imem_req_valid),
    .imem_req_ready    (imem_req_ready),
    .imem_req_addr     (imem_req_addr),
    .imem_rsp_valid    (imem_rsp_valid),
    .imem_rsp_data     (imem_rsp_data),
    .if_id_valid       (if_id_valid),
    .if_id_pc          (if_id_pc),
    .if_id_instruction (if_id_instruction)
`ifdef KAMACORE_IF_PERF_EN
    ,
    .perf_fetched      (perf_fetched),
    .perf_bubbles      (perf_bubbles)
`endif
  );

  int checks = 0;
  int errors = 0;
  int lat = 1;
  logic [63:0] sb[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // snapshot of what happened at each posedge, consumed at the following negedge
  logic        acc_q, rsp_q, redir_q, rst_q, stall_q;
  logic [31:0] acc_addr, rpc_q;
  always @(posedge clk) begin
    acc_q    <= imem_req_valid && imem_req_ready;
    acc_addr <= imem_req_addr;
    rsp_q    <= imem_rsp_valid;
    redir_q  <= redirect_valid;
    rpc_q    <= redirect_pc;
    rst_q    <= rst;
    stall_q  <= stall;
  end

  // memory responder, request-address model and slot scoreboard
  initial begin
    logic        pend, pend_stale, rsp_stale, pv;
    logic [31:0] pend_addr, rsp_addr, exp_addr, ppc;
    int          wait_n, m_fetched, m_bubbles;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    pend = 1'b0; pend_stale = 1'b0; rsp_stale = 1'b0; pv = 1'b0;
    pend_addr = '0; rsp_addr = '0; exp_addr = RESET_PC; ppc = '0;
    wait_n = 0; m_fetched = 0; m_bubbles = 0;
    forever begin
      @(negedge clk);
      if (acc_q) begin
        chk("req_addr", 64'(acc_addr), 64'(exp_addr));
        pend = 1'b1; pend_addr = acc_addr; pend_stale = redir_q; wait_n = lat - 1;
      end else if (pend && (redir_q || !rst_q)) pend_stale = 1'b1;
      if (rsp_q && rst_q && !redir_q && !rsp_stale) begin
        sb.push_back({rsp_addr, mem_data(rsp_addr)});
        exp_addr = rsp_addr + 32'd4;
      end
      if (!rst_q) exp_addr = RESET_PC;
      else if (redir_q) exp_addr = rpc_q;
      imem_rsp_valid = 1'b0;
      if (pend) begin
        if (wait_n == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_data(pend_addr);
          rsp_addr = pend_addr; rsp_stale = pend_stale; pend = 1'b0;
        end else wait_n--;
      end
      if (if_id_valid && (!pv || if_id_pc != ppc)) begin
        m_fetched++;
        chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) chk("slot_load", {if_id_pc, if_id_instruction}, sb.pop_front());
      end
      if (!if_id_valid) chk("bubble_nop", 64'(if_id_instruction), 64'(NOP_INSTR));
      if (!rst_q) begin
        m_fetched = 0; m_bubbles = 0;
      end else if (!if_id_valid && (!stall_q || redir_q)) m_bubbles++;
`ifdef KAMACORE_IF_PERF_EN
      chk("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
      chk("perf_bubbles", 64'(perf_bubbles), 64'(m_bubbles));
`endif
      pv = if_id_valid; ppc = if_id_pc;
    end
  end

  task automatic wait_load(input logic [31:0] pc, input string tag);
    for (int i = 0; i < 30 && !(if_id_valid && if_id_pc == pc); i++) @(negedge clk);
    chk(tag, {31'd0, if_id_valid, if_id_pc}, {31'd0, 1'b1, pc});
  endtask

  task automatic wait_req(input logic [31:0] a, input string tag);
    for (int i = 0; i < 30 && !imem_req_valid; i++) @(negedge clk);
    chk(tag, {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, a});
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_slot_valid", 64'(if_id_valid), 64'd0);
    chk("rst_slot_pc", 64'(if_id_pc), 64'd0);
    chk("rst_slot_instr", 64'(if_id_instruction), 64'(NOP_INSTR));
    rst = 1'b1;
    @(negedge clk);
    chk("pre_load_valid", 64'(if_id_valid), 64'd0);
    chk("pre_load_instr", 64'(if_id_instruction), 64'(NOP_INSTR));
    @(negedge clk);
    chk("load0", {31'd0, if_id_valid, if_id_pc}, {31'd0, 1'b1, 32'h0});
    @(negedge clk);
    chk("gap_valid", 64'(if_id_valid), 64'd0);
    @(negedge clk);
    chk("load4", {31'd0, if_id_valid, if_id_pc}, {31'd0, 1'b1, 32'h4});
    stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stall_hold_slot", {31'd0, if_id_valid, if_id_pc}, {31'd0, 1'b1, 32'h4});
      chk("stall_no_req", 64'(imem_req_valid), 64'd0);
    end
    stall = 1'b0;
    @(negedge clk);
    chk("release_slot", {31'd0, if_id_valid, if_id_pc}, {31'd0, 1'b1, 32'h8});
    chk("release_next_req", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, 32'hC});
    lat = 3; stall = 1'b1;
    @(negedge clk);
    chk("stall_retain_pc8", 64'(if_id_pc), 64'h8);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0; stall = 1'b0;
    chk("redir_wait_flush", {31'd0, if_id_valid, if_id_instruction}, {31'd0, 1'b0, NOP_INSTR});
    wait_load(32'h100, "redir_wait_load");
    lat = 1; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0; stall = 1'b0;
    chk("redir_stall_flush", {31'd0, if_id_valid, if_id_instruction}, {31'd0, 1'b0, NOP_INSTR});
    wait_req(32'h200, "redir_stall_req");
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; imem_req_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    chk("redir_req_addr", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, 32'hFFFF_FFFC});
    wait_load(32'hFFFF_FFFC, "wrap_load");
    chk("wrap_req", {31'd0, imem_req_valid, imem_req_addr}, {31'd0, 1'b1, 32'h0});
    wait_load(32'h0, "post_wrap_load0");
    wait_load(32'h4, "post_wrap_load4");
    lat = 3;
    @(negedge clk);
    chk("mid_wait_req_valid", 64'(imem_req_valid), 64'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst2_slot", {31'd0, if_id_valid, if_id_pc}, {31'd0, 1'b0, 32'h0});
    chk("rst2_instr", 64'(if_id_instruction), 64'(NOP_INSTR));
    chk("rst2_req_valid", 64'(imem_req_valid), 64'd0);
`ifdef KAMACORE_IF_PERF_EN
    chk("rst2_perf", {perf_fetched, perf_bubbles}, 64'd0);
`endif
    lat = 1; rst = 1'b1;
    wait_load(32'h0, "post_rst_load0");
    wait_load(32'h4, "post_rst_load4");
    repeat (5) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/kamacore_stage_if.md
Name: kamacore_stage_if

Overview:
Instruction-fetch stage. It owns the program counter and issues single-outstanding requests to instruction memory over a valid/ready request and valid-only response protocol. Fetched instructions are registered into the IF/ID slot that feeds decode. It honours decode-side stall and execute-side redirect (branch/jump), and inserts NOP bubbles on flush or when no instruction is available.

Parameters:
CPU_WIDTH, 32, data/address width; PC wraps modulo 2^CPU_WIDTH
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
stall  in  1  decode cannot accept; hold IF/ID slot
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  CPU_WIDTH  new fetch address
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  CPU_WIDTH  fetch address
imem_rsp_valid  in  1  response valid (exactly one per accepted request, ≥1 cycle later)
imem_rsp_data  in  32  fetched instruction
if_id_valid  out  1  IF/ID slot holds a real instruction
if_id_pc  out  CPU_WIDTH  PC of slot instruction
if_id_instruction  out  32  slot instruction (NOP_INSTR when invalid)

Behaviour:
- Reset (rst==0 at posedge): pc<=RESET_PC; state<=REQ; drop<=0; hold buffer empty; if_id_valid<=0, if_id_pc<=0, if_id_instruction<=NOP_INSTR. imem_req_valid is 0 while rst==0. Reset mid-transaction abandons any in-flight request; a stale response arriving after reset is discarded (drop<=1 if state was WAIT).
- imem_req_valid = rst && state==REQ; imem_req_addr = pc (stable while valid and not ready).
- FSM:
  REQ: on imem_req_ready -> WAIT.
  WAIT: on imem_rsp_valid and drop -> drop<=0, REQ (data discarded). On imem_rsp_valid, !drop, !stall -> load IF/ID slot {1, pc, data}; pc<=pc+4; REQ. On imem_rsp_valid, !drop, stall -> capture data into hold buffer; HOLD.
  HOLD: when !stall -> load slot from hold buffer; pc<=pc+4; REQ.
- Slot update when no new instruction is loaded: if stall, slot retains value. If !stall, slot becomes bubble {0, pc_of_last, NOP_INSTR}.
- Redirect has highest priority and applies regardless of stall:
  pc<=redirect_pc; slot<=bubble; hold buffer discarded.
  In REQ: if imem_req_ready in the same cycle -> WAIT with drop<=1; else stay REQ (new address presented next cycle).
  In WAIT: rsp_valid same cycle -> discard, REQ; no rsp -> drop<=1, stay WAIT.
  In HOLD: -> REQ.
- Latency: response cycle N -> slot valid at N+1. Back-to-back throughput is one instruction per 2 cycles with 1-cycle memory (single outstanding).
- PC arithmetic is unsigned CPU_WIDTH; 32'hFFFF_FFFC + 4 wraps to 0. Low two PC bits are passed through unchanged (no alignment check).

Optional Feature:
KAMACORE_IF_PERF_EN: adds outputs perf_fetched (32) and perf_bubbles (32). perf_fetched increments on each slot load with valid=1; perf_bubbles increments on each cycle the slot becomes a bubble. Both reset to 0 and wrap. Without the macro, the ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- kamacore_pkg holds CPU_WIDTH, NOP_INSTR constant, fetch FSM enum (REQ, WAIT, HOLD), and st_fetch_slot struct {valid, pc, instruction}.
- One sub-module: kamacore_fetch_hold_buffer, a one-entry capture/release register with flush input.

Test Plan:
- Reset release, RESET_PC=0, memory ready=1 with 1-cycle rsp -> addrs 0,4,8 requested; slot shows pc 0,4,8 with valid=1 every 2nd cycle; before first load, slot shows valid=0, NOP_INSTR.
- Response for pc 8 arrives while stall=1 for 3 cycles -> slot holds pc 4; no new request is issued; after stall drops, slot shows pc 8 next cycle and request for 12 follows.
- redirect_valid with redirect_pc=0x100 while in WAIT, rsp 2 cycles later -> stale rsp discarded; next slot valid has pc 0x100; slot is a bubble in the cycle after redirect.
- Redirect coincident with imem_req_ready and stall=1 -> slot flushed to bubble despite stall; in-flight data dropped; next request addr=redirect_pc.
- pc=0xFFFF_FFFC fetch -> next request addr=0x0000_0000.
- With KAMACORE_IF_PERF_EN: 5 fetches and 1 redirect -> perf_fetched=5, perf_bubbles equals counted bubble cycles; counters return to 0 after reset.
